ysyx_25040105_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer between the PC datapath, instruction memory and the decode stage. Owns the architectural fetch PC, issues one request per instruction on a valid/ready memory port, and holds each returned instruction on a valid/ready port until decode accepts it. Applies redirects (jump/branch) at any point of a fetch, discarding stale responses. Runs a response-timeout watchdog.

---
 rtl/ysyx_25040105_fetch_ctrl_if.sv | 26 ++
 rtl/ysyx_25040105_fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_ysyx_25040105_fetch_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040105_fetch_ctrl_if.sv
// rtl/ysyx_25040105_fetch_ctrl_if.sv - redirect, imem and decode ports of the fetch sequencer
interface ysyx_25040105_fetch_ctrl_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_err;
  logic        fetch_misalign;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_err, fetch_misalign
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_err, fetch_misalign
  );
endinterface

// File: rtl/ysyx_25040105_fetch_ctrl.sv
// rtl/ysyx_25040105_fetch_ctrl.sv - instruction fetch sequencer with redirect and response watchdog
// Optional misaligned-redirect trap: YSYX_25040105_FETCH_MISALIGN_EN
module ysyx_25040105_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic                          clk,
  input logic                          rst,
  ysyx_25040105_fetch_ctrl_if.master   bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC) - 32'd1;

  logic [2:0]  state;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic [31:0] wait_cnt;
  logic        err_q;
  logic        redir;
  logic        bad;
  logic        timeout_hit;

  assign redir       = bus.redirect_valid && (state != S_ERR);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt >= TO_LAST);

`ifdef YSYX_25040105_FETCH_MISALIGN_EN
  logic mis_q;
  assign bad                = redir && (bus.redirect_pc[1:0] != 2'b00);
  assign bus.fetch_misalign = mis_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_q <= 1'b0;
    end else if (bad) begin
      mis_q <= 1'b1;
    end
  end
`else
  assign bad                = 1'b0;
  assign bus.fetch_misalign = 1'b0;
`endif

  assign bus.imem_req_valid = (state == S_REQ);
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = (state == S_OUT);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.fetch_err      = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      inst_q    <= 32'd0;
      inst_pc_q <= 32'd0;
      wait_cnt  <= 32'd0;
      err_q     <= 1'b0;
    end else if (bad) begin
      // Trap before the bad address ever reaches the request port.
      state <= S_ERR;
    end else begin
      case (state)
        S_IDLE: begin
          if (redir) pc <= bus.redirect_pc;
          state <= S_REQ;
        end
        S_REQ: begin
          if (redir) pc <= bus.redirect_pc;
          if (bus.imem_req_ready) begin
            state    <= S_WAIT;
            wait_cnt <= 32'd0;
            kill     <= redir;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 32'd1;
          if (redir) pc <= bus.redirect_pc;
          if (bus.imem_resp_valid) begin
            kill <= 1'b0;
            if (kill || redir) begin
              state <= S_REQ;
            end else begin
              inst_q    <= bus.imem_resp_data;
              inst_pc_q <= pc;
              state     <= S_OUT;
            end
          end else if (redir) begin
            kill <= 1'b1;
          end else if (timeout_hit) begin
            state <= S_ERR;
            err_q <= 1'b1;
          end
        end
        S_OUT: begin
          // A redirect withdraws the instruction even if decode takes it this cycle.
          if (redir) begin
            pc    <= bus.redirect_pc;
            state <= S_REQ;
          end else if (bus.inst_ready) begin
            pc    <= pc + 32'd4;
            state <= S_REQ;
          end
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040105_fetch_ctrl.sv
// tb/tb_ysyx_25040105_fetch_ctrl.sv - bench for the fetch sequencer with transaction-level model
module tb_ysyx_25040105_fetch_ctrl;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_25040105_fetch_ctrl_if bus ();

  ysyx_25040105_fetch_ctrl #(
    .RESET_PC    (32'h8000_0000),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cmp_n  = 0;
  int fail_n = 0;

  logic [31:0] m_pc, m_inst, m_inst_pc, m_out_addr;
  bit m_idle, m_out, m_stale, m_have, m_err, m_mis;
  int m_wcnt, mem_cnt;
  bit mem_mute = 1'b0;
  bit use_nop  = 1'b1;
  int mem_delay = 1;
  int hs_n = 0;
  logic [31:0] req_log[$];
  logic [31:0] hs_pc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks the next fetch address, the outstanding request and the held instruction.
  always @(posedge clk) begin : model
    logic rv, rr, pv, iv, ir, rd;
    logic [31:0] ra, rpc, pd;
    bit nxt;
    if (!rst) begin
      m_pc = 32'h8000_0000; m_inst = 0; m_inst_pc = 0; m_out_addr = 0;
      m_idle = 1; m_out = 0; m_stale = 0; m_have = 0; m_err = 0; m_mis = 0;
      m_wcnt = 0; mem_cnt = 0;
      #1;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'd0;
    end else begin
      rv = bus.imem_req_valid; rr = bus.imem_req_ready; ra = bus.imem_req_addr;
      pv = bus.imem_resp_valid; pd = bus.imem_resp_data;
      iv = bus.inst_valid; ir = bus.inst_ready;
      rd = bus.redirect_valid; rpc = bus.redirect_pc;
      m_idle = 0;
      if (!m_err) begin
        if (pv && m_out) begin
          m_out = 0;
          if (!m_stale && !rd) begin
            m_have = 1; m_inst = pd; m_inst_pc = m_out_addr;
          end
          m_stale = 0;
        end else if (m_out) begin
          m_wcnt++;
          if (rd) m_stale = 1;
          else if (m_wcnt == TO) m_err = 1;
        end
        if (iv && ir) begin
          hs_n++;
          hs_pc.push_back(m_inst_pc);
        end
        if (iv && (ir || rd)) begin
          if (!rd) m_pc = m_inst_pc + 32'd4;
          m_have = 0;
        end
        if (rv && rr) begin
          req_log.push_back(ra);
          m_out = 1; m_stale = rd; m_wcnt = 0; m_out_addr = ra;
          mem_cnt = mem_delay - 1;
        end
        if (rd) begin
          m_pc = rpc;
`ifdef YSYX_25040105_FETCH_MISALIGN_EN
          if (rpc[1:0] != 2'b00) begin
            m_err = 1; m_mis = 1; m_have = 0;
          end
`endif
        end
      end
      #1;
      nxt = m_out && !m_err && !mem_mute && (mem_cnt == 0);
      if (m_out && mem_cnt > 0) mem_cnt--;
      bus.imem_resp_valid = nxt;
      bus.imem_resp_data  = use_nop ? 32'h0000_0013 : (m_out_addr ^ 32'h5A5A_0000);
    end
  end

  always @(negedge clk) begin : compare
    logic exp_req;
    if (rst) begin
      exp_req = !m_idle && !m_out && !m_have && !m_err;
      chk("req_valid", {31'd0, bus.imem_req_valid}, {31'd0, exp_req});
      if (exp_req) chk("req_addr", bus.imem_req_addr, m_pc);
      chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_have});
      if (m_have) begin
        chk("inst", bus.inst, m_inst);
        chk("inst_pc", bus.inst_pc, m_inst_pc);
      end
      chk("fetch_err", {31'd0, bus.fetch_err}, {31'd0, m_err});
      chk("fetch_misalign", {31'd0, bus.fetch_misalign}, {31'd0, m_mis});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_req_accept(input string name);
    int sz = req_log.size();
    int n = 0;
    while (req_log.size() == sz && n < 60) begin
      tick();
      n++;
    end
    chk(name, 32'(req_log.size() != sz), 32'd1);
  endtask

  task automatic wait_inst_valid(input string name);
    int n = 0;
    while (!bus.inst_valid && n < 60) begin
      tick();
      n++;
    end
    chk(name, {31'd0, bus.inst_valid}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] hi, hp;
    int h0, rs, n;
    bus.redirect_valid = 0; bus.redirect_pc = 0;
    bus.imem_req_ready = 0; bus.inst_ready = 0;
    rst = 0;
    tick(3);
    chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_err", {31'd0, bus.fetch_err}, 32'd0);
    chk("rst_addr", bus.imem_req_addr, 32'h8000_0000);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);

    // zero-wait stream of nops
    bus.imem_req_ready = 1; bus.inst_ready = 1; rst = 1;
    tick(1);
    chk("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("first_req_addr", bus.imem_req_addr, 32'h8000_0000);
    wait_inst_valid("t1_iv");
    chk("t1_inst", bus.inst, 32'h0000_0013);
    h0 = hs_n;
    tick(9);
    chk("t1_rate", 32'(hs_n - h0), 32'd3);
    chk("t1_req0", req_log[0], 32'h8000_0000);
    chk("t1_req1", req_log[1], 32'h8000_0004);
    chk("t1_req2", req_log[2], 32'h8000_0008);
    chk("t1_hs0", hs_pc[0], 32'h8000_0000);
    chk("t1_hs1", hs_pc[1], 32'h8000_0004);
    chk("t1_hs2", hs_pc[2], 32'h8000_0008);

    // decode stall holds the instruction
    bus.inst_ready = 0;
    hi = bus.inst; hp = bus.inst_pc; rs = req_log.size();
    chk("t2_pc", hp, 32'h8000_000C);
    chk("t2_inst", hi, 32'h0000_0013);
    tick(5);
    chk("t2_hold_inst", bus.inst, 32'h0000_0013);
    chk("t2_hold_pc", bus.inst_pc, 32'h8000_000C);
    chk("t2_hold_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("t2_no_req", 32'(req_log.size()), 32'(rs));
    use_nop = 0;
    bus.inst_ready = 1;
    wait_req_accept("t2_acc");
    chk("t2_next_addr", req_log[$], 32'h8000_0010);

    // redirect while a slow response is pending
    mem_delay = 4;
    wait_inst_valid("t3_iv");
    wait_req_accept("t3_acc");
    chk("t3_acc_addr", req_log[$], 32'h8000_0014);
    bus.redirect_valid = 1; bus.redirect_pc = 32'h8000_0100;
    tick(1);
    bus.redirect_valid = 0;
    h0 = hs_n;
    wait_req_accept("t3_req");
    chk("t3_req_addr", req_log[$], 32'h8000_0100);
    chk("t3_no_inst", 32'(hs_n), 32'(h0));

    // redirect in OUT coinciding with decode accept
    mem_delay = 1;
    wait_inst_valid("t4_iv");
    chk("t4_inst_pc", bus.inst_pc, 32'h8000_0100);
    chk("t4_inst", bus.inst, 32'hDA5A_0100);
    bus.redirect_valid = 1; bus.redirect_pc = 32'h8000_0200;
    tick(1);
    bus.redirect_valid = 0;
    chk("t4_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("t4_req_addr", bus.imem_req_addr, 32'h8000_0200);
    chk("t4_inst_gone", {31'd0, bus.inst_valid}, 32'd0);
    wait_req_accept("t4_acc");
    chk("t4_acc_addr", req_log[$], 32'h8000_0200);

    // misaligned redirect
    wait_inst_valid("t5_iv");
    bus.redirect_valid = 1; bus.redirect_pc = 32'h8000_0102;
    tick(1);
    bus.redirect_valid = 0;
`ifdef YSYX_25040105_FETCH_MISALIGN_EN
    chk("t5_misalign", {31'd0, bus.fetch_misalign}, 32'd1);
    chk("t5_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    rs = req_log.size();
    tick(5);
    chk("t5_log", 32'(req_log.size()), 32'(rs));
    chk("t5_still", {31'd0, bus.imem_req_valid}, 32'd0);
`else
    chk("t5_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("t5_req_addr", bus.imem_req_addr, 32'h8000_0102);
    wait_inst_valid("t5_iv2");
    chk("t5_inst_pc", bus.inst_pc, 32'h8000_0102);
`endif
    rst = 0;
    tick(2);
    rst = 1;

    // watchdog with a silent memory
    mem_mute = 1;
    wait_req_accept("t6_acc");
    chk("t6_addr", req_log[$], 32'h8000_0000);
    tick(7);
    chk("t6_err_early", {31'd0, bus.fetch_err}, 32'd0);
    tick(1);
    chk("t6_err", {31'd0, bus.fetch_err}, 32'd1);
    rs = req_log.size();
    bus.redirect_valid = 1; bus.redirect_pc = 32'h8000_0300;
    tick(5);
    bus.redirect_valid = 0;
    chk("t6_req_off", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("t6_inst_off", {31'd0, bus.inst_valid}, 32'd0);
    chk("t6_log", 32'(req_log.size()), 32'(rs));

    // asynchronous reset out of ERR, then mid-WAIT
    #2 rst = 0;
    #1 chk("t7_err_clr", {31'd0, bus.fetch_err}, 32'd0);
    chk("t7_req_off", {31'd0, bus.imem_req_valid}, 32'd0);
    tick(1);
    rst = 1; mem_mute = 0; mem_delay = 1;
    h0 = hs_n; n = 0;
    while (hs_n < h0 + 2 && n < 60) begin
      tick();
      n++;
    end
    chk("t7_two_inst", 32'(hs_n - h0), 32'd2);
    mem_delay = 4;
    wait_req_accept("t7_acc");
    chk("t7_acc_addr", req_log[$], 32'h8000_0008);
    tick(1);
    #2 rst = 0;
    #1 chk("t7_pc_reset", bus.imem_req_addr, 32'h8000_0000);
    chk("t7_req_idle", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("t7_inst_idle", {31'd0, bus.inst_valid}, 32'd0);
    tick(1);
    rst = 1; mem_delay = 1;
    tick(1);
    chk("t7_first_req", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("t7_first_addr", bus.imem_req_addr, 32'h8000_0000);
    wait_inst_valid("t7_iv");
    chk("t7_inst_pc", bus.inst_pc, 32'h8000_0000);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule
